// File: rtl/adder_bist_ctrl.sv
// BIST controller for the N-bit ripple adder: LFSR operand generation, MISR compaction, golden compare.
// Optional macro ADDER_BIST_SIG_OUT_EN exposes the MISR signature on sig_out.
module adder_bist_ctrl #(
    parameter int          N       = 16,
    parameter int          PAT_NUM = 64,
    parameter logic [31:0] SEED    = 32'hACE1_1234,
    parameter logic [N:0]  GOLDEN  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bist_start,
    input  logic         bist_clr,
    input  logic [N-1:0] sum,
    input  logic         co,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         ci,
    output logic [5:0]   com_res,
    output logic         sel
`ifdef ADDER_BIST_SIG_OUT_EN
    ,
    output logic [N:0]   sig_out
`endif
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_CHECK = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    localparam logic [9:0] CNT_LAST = 10'(PAT_NUM - 1);

    logic [1:0]   r_state;
    logic [31:0]  r_lfsr;
    logic [N:0]   r_misr;
    logic [9:0]   r_cnt;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_ci;
    logic         r_pass;
    logic         r_fail;
    logic         r_sel;
    logic [5:0]   r_comRes;

    logic [31:0]  w_lfsrStep;
    logic [N:0]   w_misrStep;
    logic         w_sigMatch;

    logic [1:0]   w_stateNext;
    logic [31:0]  w_lfsrNext;
    logic [N:0]   w_misrNext;
    logic [9:0]   w_cntNext;
    logic         w_passNext;
    logic         w_failNext;
    logic         w_opsLoad;
    logic         w_busyNext;
    logic         w_doneNext;

    assign w_lfsrStep = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
    assign w_misrStep = {r_misr[N-1:0], r_misr[N]} ^ {co, sum};
    assign w_sigMatch = (r_misr == GOLDEN);

    always_comb begin
        w_stateNext = r_state;
        w_lfsrNext  = r_lfsr;
        w_misrNext  = r_misr;
        w_cntNext   = r_cnt;
        w_passNext  = r_pass;
        w_failNext  = r_fail;
        case (r_state)
            S_IDLE: begin
                if (bist_start) begin
                    w_stateNext = S_RUN;
                    w_lfsrNext  = SEED;
                    w_misrNext  = '0;
                    w_cntNext   = '0;
                    w_passNext  = 1'b0;
                    w_failNext  = 1'b0;
                end
            end
            S_RUN: begin
                w_lfsrNext = w_lfsrStep;
                w_misrNext = w_misrStep;
                w_cntNext  = r_cnt + 10'd1;
                if (r_cnt == CNT_LAST) begin
                    w_stateNext = S_CHECK;
                end
            end
            S_CHECK: begin
                w_passNext  = w_sigMatch;
                w_failNext  = ~w_sigMatch;
                w_stateNext = S_DONE;
            end
            S_DONE: begin
                if (bist_clr) begin
                    w_stateNext = S_IDLE;
                    w_passNext  = 1'b0;
                    w_failNext  = 1'b0;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Operands and status are registered from next-state values so they line up with the state they describe.
    assign w_opsLoad  = (w_stateNext == S_RUN);
    assign w_busyNext = (w_stateNext == S_RUN) || (w_stateNext == S_CHECK);
    assign w_doneNext = (w_stateNext == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_lfsr   <= SEED;
            r_misr   <= '0;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_ci     <= 1'b0;
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_sel    <= 1'b0;
            r_comRes <= 6'b000000;
        end else begin
            r_state  <= w_stateNext;
            r_lfsr   <= w_lfsrNext;
            r_misr   <= w_misrNext;
            r_cnt    <= w_cntNext;
            r_a      <= w_opsLoad ? w_lfsrNext[N-1:0] : '0;
            r_b      <= w_opsLoad ? w_lfsrNext[N+15:16] : '0;
            r_ci     <= w_opsLoad ? (w_lfsrNext[31] ^ w_lfsrNext[0]) : 1'b0;
            r_pass   <= w_passNext;
            r_fail   <= w_failNext;
            r_sel    <= w_doneNext;
            r_comRes <= {w_busyNext, w_doneNext, w_passNext, w_failNext, w_stateNext};
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign ci      = r_ci;
    assign com_res = r_comRes;
    assign sel     = r_sel;

`ifdef ADDER_BIST_SIG_OUT_EN
    // The MISR only moves during RUN and is cleared by start, so it is already frozen from CHECK on.
    assign sig_out = r_misr;
`endif

endmodule

// File: doc/adder_bist_ctrl.md
Name: adder_bist_ctrl

Overview:
- Built-in self-test controller for the N-bit ripple adder.
- Drives pseudo-random operands into the adder and compacts the returned sum/co into a MISR signature.
- Compares the signature against a golden value and produces the 6-bit com_res status word plus the sel line that feed the downstream 2:1 output mux.
- Sits directly upstream of that mux and beside the adder.

Parameters:
- N, 16: adder width; legal range 4..16.
- PAT_NUM, 64: patterns applied per run; legal range 2..1023.
- SEED, 32'hACE1_1234: LFSR load value; must be nonzero.
- GOLDEN, 17'h0: expected MISR signature, N+1 bits; the bench overrides it with its model value.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- bist_start  in  1  one-cycle pulse; starts a run from IDLE.
- bist_clr  in  1  returns DONE to IDLE.
- sum  in  N  adder sum from the DUT adder.
- co  in  1  adder carry-out.
- a  out  N  adder operand A (registered).
- b  out  N  adder operand B (registered).
- ci  out  1  adder carry-in (registered).
- com_res  out  6  status word to the output mux.
- sel  out  1  mux select; 1 = present com_res, 0 = functional sum/co.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, lfsr=SEED, misr=0, cnt=0, a=0, b=0, ci=0, pass=0, fail=0, sel=0, com_res=6'b000000.
- Reset asserted mid-run aborts the run at the next edge; no partial status survives.
- States, encoded on com_res[1:0]: IDLE=00, RUN=01, CHECK=10, DONE=11.
- IDLE:
  - a, b, ci held at 0.
  - On bist_start=1: lfsr<=SEED, misr<=0, cnt<=0, pass<=0, fail<=0; next state RUN.
- RUN:
  - Operands are registered from the lfsr: a=lfsr[N-1:0], b=lfsr[N+15:16], ci=lfsr[31]^lfsr[0].
  - The first RUN cycle presents SEED-derived operands.
  - Each RUN edge:
    - misr <= {misr[N-1:0], misr[N]} ^ {co, sum}, i.e. rotate-left then XOR; sum/co are sampled combinationally from the current operands.
    - lfsr advances as a 32-bit Fibonacci LFSR, taps 32,22,2,1: lfsr <= {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
    - cnt increments.
  - When cnt==PAT_NUM-1 that edge captures the last pattern; next state CHECK.
  - Exactly PAT_NUM patterns are compacted.
- CHECK (one cycle):
  - a, b, ci return to 0.
  - pass <= (misr==GOLDEN); fail <= ~(misr==GOLDEN); next state DONE.
- DONE:
  - sel=1; status held stable.
  - bist_clr=1 -> IDLE, with pass, fail and sel cleared.
  - bist_start is ignored in DONE.
- com_res = {busy, done, pass, fail, state[1:0]}, registered:
  - busy=1 in RUN or CHECK.
  - done=1 in DONE only.
- sel is a registered output: 1 exactly while state==DONE, otherwise 0.
- Latency: start pulse at edge t puts state RUN for cycles t+1..t+PAT_NUM, CHECK at t+PAT_NUM+1, DONE from t+PAT_NUM+2.
- Boundary conditions:
  - bist_start during RUN or CHECK is ignored; no restart.
  - bist_start and bist_clr both high in IDLE: start wins.
  - In DONE only bist_clr acts.
  - cnt is 10 bits and never wraps within a legal PAT_NUM.
  - misr is N+1 bits wide; co maps to bit N.

Optional Feature:
- Macro: ADDER_BIST_SIG_OUT_EN.
- Defined: adds output port sig_out, N+1 bits, holding the misr register.
  - Reset value 0.
  - Frozen from CHECK onward until the next start, so the bench or a scan reader can inspect failing signatures.
- Undefined: port absent, no extra logic; the misr is visible only through pass/fail.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random inputs -> a=b=0, ci=0, sel=0, com_res=6'b000000.
2. Golden run: GOLDEN set to the bench-model signature for SEED, PAT_NUM=64, good adder; pulse bist_start -> com_res=6'b100001 for 64 cycles, 6'b100010 for 1 cycle, then 6'b011011 with sel=1.
3. Fault run: same as scenario 2 with sum[0] stuck at 0 forced in the bench adder -> DONE with com_res=6'b010111, sel=1.
4. Operand sequence: check a, b, ci on the first three RUN cycles against the LFSR model from SEED=32'hACE1_1234 -> the first cycle gives a=16'h1234, b=16'hACE1, ci=1.
5. Control corners:
   - bist_start pulsed mid-RUN -> pattern count unchanged (64).
   - bist_clr in DONE -> IDLE next cycle, sel=0, com_res=0.
   - rst asserted at RUN cycle 30 -> IDLE; a subsequent full run still passes.
6. With ADDER_BIST_SIG_OUT_EN: in fault run -> sig_out equals the bench model faulty signature and stays stable through DONE.
